// File: rtl/atm_pkg.sv
// Shared types for the multi-account ATM controller: FSM states,
// transaction type codes and error codes reported on err_code.
package atm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_PIN  = 4'd1,
        ST_CHECK_PIN = 4'd2,
        ST_MENU      = 4'd3,
        ST_SHOW_BAL  = 4'd4,
        ST_CHECK_WD  = 4'd5,
        ST_DISPENSE  = 4'd6,
        ST_DEPOSIT   = 4'd7,
        ST_EJECT     = 4'd8,
        ST_RETAIN    = 4'd9
    } state_t;

    localparam logic [1:0] TXN_END = 2'b00;
    localparam logic [1:0] TXN_BAL = 2'b01;
    localparam logic [1:0] TXN_WD  = 2'b10;
    localparam logic [1:0] TXN_DEP = 2'b11;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_BAD_PIN   = 3'd1;
    localparam logic [2:0] ERR_NO_FUNDS  = 3'd2;
    localparam logic [2:0] ERR_DAILY     = 3'd3;
    localparam logic [2:0] ERR_DENOM     = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd5;
    localparam logic [2:0] ERR_BLOCKED   = 3'd6;
    localparam logic [2:0] ERR_DISPENSER = 3'd7;

endpackage

// File: rtl/atm_acct_bank.sv
// Per-account state: balance, daily-withdrawn total, consecutive PIN
// failures and lockout flag, with one read port on the selected account.
module atm_acct_bank
    import atm_pkg::*;
#(
    parameter int AMT_W        = 16,
    parameter int NUM_ACCTS    = 4,
    parameter int ACCT_W       = 2,
    parameter int FAIL_W       = 2,
    parameter int INIT_BALANCE = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ACCT_W-1:0]    i_acct,
    input  logic [AMT_W-1:0]     i_amount,
    input  logic                 i_debit,
    input  logic                 i_credit,
    input  logic                 i_fail,
    input  logic                 i_clear_fail,
    input  logic                 i_block,
    input  logic                 i_rollover,
    output logic [AMT_W-1:0]     o_balance,
    output logic [AMT_W-1:0]     o_daily,
    output logic [FAIL_W-1:0]    o_fail_cnt,
    output logic [NUM_ACCTS-1:0] o_blocked
);

    logic [AMT_W-1:0]  w_bal_arr   [NUM_ACCTS];
    logic [AMT_W-1:0]  w_daily_arr [NUM_ACCTS];
    logic [FAIL_W-1:0] w_fail_arr  [NUM_ACCTS];
    logic [AMT_W:0]    w_credit_sum;
    logic [AMT_W-1:0]  w_credit_bal;

    assign o_balance  = w_bal_arr[i_acct];
    assign o_daily    = w_daily_arr[i_acct];
    assign o_fail_cnt = w_fail_arr[i_acct];

    // Deposits only ever land on the selected account, so one saturating adder serves all.
    assign w_credit_sum = {1'b0, o_balance} + {1'b0, i_amount};
    assign w_credit_bal = w_credit_sum[AMT_W] ? '1 : w_credit_sum[AMT_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACCTS; gi++) begin : g_acct
            logic              w_sel;
            logic [AMT_W-1:0]  r_balance;
            logic [AMT_W-1:0]  r_daily;
            logic [FAIL_W-1:0] r_fail_cnt;
            logic              r_blocked;

            assign w_sel = (i_acct == ACCT_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_balance  <= AMT_W'(INIT_BALANCE);
                    r_daily    <= '0;
                    r_fail_cnt <= '0;
                    r_blocked  <= 1'b0;
                end else begin
                    if (w_sel && i_debit)
                        r_balance <= r_balance - i_amount;
                    else if (w_sel && i_credit)
                        r_balance <= w_credit_bal;

                    // A debit coinciding with rollover starts the new day at the debit amount.
                    if (w_sel && i_debit)
                        r_daily <= i_rollover ? i_amount : r_daily + i_amount;
                    else if (i_rollover)
                        r_daily <= '0;

                    if (w_sel && i_block) begin
                        r_blocked  <= 1'b1;
                        r_fail_cnt <= '0;
                    end else if (w_sel && i_fail) begin
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                    end else if (w_sel && i_clear_fail) begin
                        r_fail_cnt <= '0;
                    end
                end
            end

            assign w_bal_arr[gi]   = r_balance;
            assign w_daily_arr[gi] = r_daily;
            assign w_fail_arr[gi]  = r_fail_cnt;
            assign o_blocked[gi]   = r_blocked;
        end
    endgenerate

endmodule

// File: rtl/atm_multi_account_ctrl.sv
// ATM session FSM: card/PIN handling, account menu, withdrawal checks,
// dispenser handshake and inactivity timeout over a bank of accounts.
module atm_multi_account_ctrl
    import atm_pkg::*;
#(
    parameter int AMT_W         = 16,
    parameter int NUM_ACCTS     = 4,
    parameter int ACCT_W        = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1,
    parameter int MAX_PIN_TRIES = 3,
    parameter int INIT_BALANCE  = 1000,
    parameter int DAILY_LIMIT   = 500,
    parameter int DENOM         = 20,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              card_in,
    input  logic [ACCT_W-1:0] acct_id,
    input  logic              pin_valid,
    input  logic              pin_ok,
    input  logic              txn_valid,
    input  logic [1:0]        txn_type,
    input  logic [AMT_W-1:0]  amount,
    input  logic              day_rollover,
    output logic              dispense_req,
    output logic [AMT_W-1:0]  dispense_amt,
    input  logic              dispense_done,
    output logic [AMT_W-1:0]  balance_out,
    output logic              balance_valid,
    output logic              card_eject,
    output logic              card_retained,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic [3:0]        state_out,
    output logic              busy
);

    localparam int FAIL_W = $clog2(MAX_PIN_TRIES + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    logic [ACCT_W-1:0]  r_acct;
    logic               r_pin_ok;
    logic [AMT_W-1:0]   r_amount;
    logic [TMR_W-1:0]   r_timer;
    logic               r_dispense_req;
    logic [AMT_W-1:0]   r_dispense_amt;
    logic [AMT_W-1:0]   r_balance_out;
    logic               r_balance_valid;
    logic               r_card_eject;
    logic               r_card_retained;
    logic               r_err_valid;
    logic [2:0]         r_err_code;
    logic               r_busy;

    logic [AMT_W-1:0]     w_rd_balance;
    logic [AMT_W-1:0]     w_rd_daily;
    logic [FAIL_W-1:0]    w_rd_fail;
    logic [NUM_ACCTS-1:0] w_blocked_vec;
    logic                 w_debit;
    logic                 w_credit;
    logic                 w_fail;
    logic                 w_clear_fail;
    logic                 w_block;
    logic                 w_last_try;
    logic [AMT_W-1:0]     w_bank_amt;
    logic                 w_timeout;
    logic                 w_bad_denom;
    logic                 w_no_funds;
    logic                 w_over_limit;

    assign w_timeout    = (r_timer == TMR_W'(TIMEOUT_CYC - 1));
    assign w_last_try   = (({1'b0, w_rd_fail} + 1'b1) >= (FAIL_W + 1)'(MAX_PIN_TRIES));
    assign w_debit      = (r_state == ST_DISPENSE) && dispense_done;
    assign w_credit     = (r_state == ST_DEPOSIT);
    assign w_fail       = (r_state == ST_CHECK_PIN) && !r_pin_ok;
    assign w_clear_fail = (r_state == ST_CHECK_PIN) && r_pin_ok;
    assign w_block      = w_fail && w_last_try;
    assign w_bank_amt   = w_debit ? r_dispense_amt : r_amount;

    assign w_bad_denom  = (r_amount == '0) || ((r_amount % AMT_W'(DENOM)) != '0);
    assign w_no_funds   = (r_amount > w_rd_balance);
    assign w_over_limit = (({1'b0, w_rd_daily} + {1'b0, r_amount}) > (AMT_W + 1)'(DAILY_LIMIT));

    atm_acct_bank #(
        .AMT_W        (AMT_W),
        .NUM_ACCTS    (NUM_ACCTS),
        .ACCT_W       (ACCT_W),
        .FAIL_W       (FAIL_W),
        .INIT_BALANCE (INIT_BALANCE)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .i_acct       (r_acct),
        .i_amount     (w_bank_amt),
        .i_debit      (w_debit),
        .i_credit     (w_credit),
        .i_fail       (w_fail),
        .i_clear_fail (w_clear_fail),
        .i_block      (w_block),
        .i_rollover   (day_rollover),
        .o_balance    (w_rd_balance),
        .o_daily      (w_rd_daily),
        .o_fail_cnt   (w_rd_fail),
        .o_blocked    (w_blocked_vec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_acct          <= '0;
            r_pin_ok        <= 1'b0;
            r_amount        <= '0;
            r_timer         <= '0;
            r_dispense_req  <= 1'b0;
            r_dispense_amt  <= '0;
            r_balance_out   <= '0;
            r_balance_valid <= 1'b0;
            r_card_eject    <= 1'b0;
            r_card_retained <= 1'b0;
            r_err_valid     <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_busy          <= 1'b0;
        end else begin
            // Pulses last one cycle; the timer only runs while waiting for an event.
            r_balance_valid <= 1'b0;
            r_card_eject    <= 1'b0;
            r_card_retained <= 1'b0;
            r_err_valid     <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_timer         <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (card_in) begin
                        r_acct <= acct_id;
                        r_busy <= 1'b1;
                        if (w_blocked_vec[acct_id]) begin
                            r_state         <= ST_RETAIN;
                            r_card_retained <= 1'b1;
                            r_err_valid     <= 1'b1;
                            r_err_code      <= ERR_BLOCKED;
                        end else begin
                            r_state <= ST_WAIT_PIN;
                        end
                    end
                end
                ST_WAIT_PIN: begin
                    if (pin_valid) begin
                        r_pin_ok <= pin_ok;
                        r_state  <= ST_CHECK_PIN;
                    end else if (w_timeout) begin
                        r_state      <= ST_EJECT;
                        r_card_eject <= 1'b1;
                        r_err_valid  <= 1'b1;
                        r_err_code   <= ERR_TIMEOUT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_CHECK_PIN: begin
                    if (r_pin_ok) begin
                        r_state <= ST_MENU;
                    end else begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_BAD_PIN;
                        if (w_last_try) begin
                            r_state         <= ST_RETAIN;
                            r_card_retained <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_PIN;
                        end
                    end
                end
                ST_MENU: begin
                    if (txn_valid) begin
                        r_amount <= amount;
                        case (txn_type)
                            TXN_BAL: begin
                                r_state         <= ST_SHOW_BAL;
                                r_balance_valid <= 1'b1;
                                r_balance_out   <= w_rd_balance;
                            end
                            TXN_WD:  r_state <= ST_CHECK_WD;
                            TXN_DEP: r_state <= ST_DEPOSIT;
                            default: begin
                                r_state      <= ST_EJECT;
                                r_card_eject <= 1'b1;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_state      <= ST_EJECT;
                        r_card_eject <= 1'b1;
                        r_err_valid  <= 1'b1;
                        r_err_code   <= ERR_TIMEOUT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_SHOW_BAL: r_state <= ST_MENU;
                ST_CHECK_WD: begin
                    r_state <= ST_MENU;
                    if (w_bad_denom) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_DENOM;
                    end else if (w_no_funds) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_NO_FUNDS;
                    end else if (w_over_limit) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_DAILY;
                    end else begin
                        r_state        <= ST_DISPENSE;
                        r_dispense_req <= 1'b1;
                        r_dispense_amt <= r_amount;
                    end
                end
                ST_DISPENSE: begin
                    if (dispense_done) begin
                        r_dispense_req <= 1'b0;
                        r_state        <= ST_MENU;
                    end else if (w_timeout) begin
                        r_dispense_req <= 1'b0;
                        r_state        <= ST_EJECT;
                        r_card_eject   <= 1'b1;
                        r_err_valid    <= 1'b1;
                        r_err_code     <= ERR_DISPENSER;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DEPOSIT: r_state <= ST_MENU;
                ST_EJECT, ST_RETAIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dispense_req  = r_dispense_req;
    assign dispense_amt  = r_dispense_amt;
    assign balance_out   = r_balance_out;
    assign balance_valid = r_balance_valid;
    assign card_eject    = r_card_eject;
    assign card_retained = r_card_retained;
    assign err_valid     = r_err_valid;
    assign err_code      = r_err_code;
    assign state_out     = r_state;
    assign busy          = r_busy;

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Self-checking bench: directed scenarios plus randomized sessions scored
// against an account-level model of balances, daily totals and lockouts.
module tb_atm_multi_account_ctrl;

    localparam int TIMEOUT = 1024;
    localparam int MAXBAL  = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic        card_in, pin_valid, pin_ok, txn_valid, day_rollover, dispense_done;
    logic [1:0]  acct_id, txn_type;
    logic [15:0] amount;
    logic        dispense_req, balance_valid, card_eject, card_retained, err_valid, busy;
    logic [15:0] dispense_amt, balance_out;
    logic [2:0]  err_code;
    logic [3:0]  state_out;

    atm_multi_account_ctrl dut (
        .clk(clk), .reset(reset), .card_in(card_in), .acct_id(acct_id),
        .pin_valid(pin_valid), .pin_ok(pin_ok), .txn_valid(txn_valid),
        .txn_type(txn_type), .amount(amount), .day_rollover(day_rollover),
        .dispense_req(dispense_req), .dispense_amt(dispense_amt),
        .dispense_done(dispense_done), .balance_out(balance_out),
        .balance_valid(balance_valid), .card_eject(card_eject),
        .card_retained(card_retained), .err_valid(err_valid),
        .err_code(err_code), .state_out(state_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Account model
    int m_bal[4];
    int m_daily[4];
    int m_fail[4];
    bit m_blocked[4];

    // Event log filled by the monitor; tests consume it through read pointers
    int   err_q[$];
    int   bal_q[$];
    int   disp_q[$];
    int   eject_cnt = 0;
    int   retain_cnt = 0;
    bit   amt_unstable = 1'b0;
    logic prev_req = 1'b0;
    logic [15:0] held_amt = '0;
    int   err_rd = 0, bal_rd = 0, disp_rd = 0;

    always @(posedge clk) begin
        #1;
        if (err_valid) err_q.push_back(int'(err_code));
        if (balance_valid) bal_q.push_back(int'(balance_out));
        if (card_eject) eject_cnt++;
        if (card_retained) retain_cnt++;
        if (dispense_req && !prev_req) begin
            disp_q.push_back(int'(dispense_amt));
            held_amt = dispense_amt;
        end else if (dispense_req && dispense_amt !== held_amt) begin
            amt_unstable = 1'b1;
        end
        prev_req = dispense_req;
    end

    function automatic int next_err();
        if (err_rd >= err_q.size()) return -1;
        err_rd++;
        return err_q[err_rd-1];
    endfunction

    function automatic int next_bal();
        if (bal_rd >= bal_q.size()) return -1;
        bal_rd++;
        return bal_q[bal_rd-1];
    endfunction

    function automatic int next_disp();
        if (disp_rd >= disp_q.size()) return -1;
        disp_rd++;
        return disp_q[disp_rd-1];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_bal[i] = 1000; m_daily[i] = 0; m_fail[i] = 0; m_blocked[i] = 1'b0;
        end
    endfunction

    function automatic int exp_wd(int a, int amt);
        if (amt == 0 || (amt % 20) != 0) return 4;
        if (amt > m_bal[a]) return 2;
        if (m_daily[a] + amt > 500) return 3;
        return 0;
    endfunction

    function automatic void model_debit(int a, int amt, bit roll);
        if (roll) for (int i = 0; i < 4; i++) m_daily[i] = 0;
        m_bal[a] -= amt;
        m_daily[a] += amt;
    endfunction

    function automatic void model_deposit(int a, int amt);
        m_bal[a] = (m_bal[a] + amt > MAXBAL) ? MAXBAL : m_bal[a] + amt;
    endfunction

    function automatic bit model_wrong_pin(int a);
        m_fail[a]++;
        if (m_fail[a] >= 3) begin
            m_blocked[a] = 1'b1;
            m_fail[a] = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_card(int a);
        @(negedge clk); card_in = 1'b1; acct_id = a[1:0];
        @(negedge clk); card_in = 1'b0;
    endtask

    task automatic pulse_pin(bit ok);
        @(negedge clk); pin_valid = 1'b1; pin_ok = ok;
        @(negedge clk); pin_valid = 1'b0; pin_ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_txn(int t, int a);
        @(negedge clk); txn_valid = 1'b1; txn_type = t[1:0]; amount = a[15:0];
        @(negedge clk); txn_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_roll();
        @(negedge clk); day_rollover = 1'b1;
        @(negedge clk); day_rollover = 1'b0;
        for (int i = 0; i < 4; i++) m_daily[i] = 0;
    endtask

    task automatic finish_dispense(int delay, bit roll);
        cyc(delay);
        @(negedge clk); dispense_done = 1'b1; day_rollover = roll;
        @(negedge clk); dispense_done = 1'b0; day_rollover = 1'b0;
    endtask

    task automatic open_session(int a);
        pulse_card(a);
        pulse_pin(1'b1);
        m_fail[a] = 0;
    endtask

    task automatic wait_err(int limit, output int code, output int waited);
        waited = 0;
        while (err_rd >= err_q.size() && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        code = next_err();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        model_reset();
        cyc(1);
        err_rd = err_q.size(); bal_rd = bal_q.size(); disp_rd = disp_q.size();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (state_out !== 4'd0) begin
            $display("FAIL reset_state: got %0d, expected 0", state_out); n_fail++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %0b, expected 0", busy); n_fail++;
        end
        n_tests++;
        if ({dispense_req, dispense_amt, balance_out, balance_valid, card_eject,
             card_retained, err_valid, err_code} !== '0) begin
            $display("FAIL reset_outputs: req=%0b amt=%0d bal=%0d errv=%0b, expected all 0",
                     dispense_req, dispense_amt, balance_out, err_valid); n_fail++;
        end
    endtask

    task automatic test_withdraw_basic();
        int got, e0;
        e0 = eject_cnt;
        pulse_card(2);
        n_tests++;
        if (state_out !== 4'd1 || busy !== 1'b1) begin
            $display("FAIL card_to_wait_pin: got state %0d busy %0b, expected 1 1", state_out, busy); n_fail++;
        end
        pulse_pin(1'b1);
        m_fail[2] = 0;
        n_tests++;
        if (state_out !== 4'd3) begin
            $display("FAIL pin_ok_to_menu: got %0d, expected 3", state_out); n_fail++;
        end
        pulse_txn(2, 200);
        n_tests++;
        if (dispense_req !== 1'b1) begin
            $display("FAIL wd200_req: got %0b, expected 1", dispense_req); n_fail++;
        end
        finish_dispense(5, 1'b0);
        model_debit(2, 200, 1'b0);
        got = next_disp();
        n_tests++;
        if (got != 200) begin
            $display("FAIL wd200_amt: got %0d, expected 200", got); n_fail++;
        end
        n_tests++;
        if (dispense_req !== 1'b0) begin
            $display("FAIL wd200_req_drop: got %0b, expected 0", dispense_req); n_fail++;
        end
        pulse_txn(1, 0);
        got = next_bal();
        n_tests++;
        if (got != 800) begin
            $display("FAIL wd200_balance: got %0d, expected 800", got); n_fail++;
        end
        pulse_txn(0, 0);
        n_tests++;
        if (eject_cnt != e0 + 1 || amt_unstable) begin
            $display("FAIL wd200_eject: got ejects %0d unstable %0b, expected %0d 0",
                     eject_cnt - e0, amt_unstable, 1); n_fail++;
        end
        $display("[TB] txn acct=2 withdraw 200 balance=%0d", m_bal[2]);
    endtask

    task automatic test_lockout();
        int got, r0;
        r0 = retain_cnt;
        pulse_card(1);
        for (int i = 0; i < 3; i++) begin
            pulse_pin(1'b0);
            void'(model_wrong_pin(1));
            got = next_err();
            n_tests++;
            if (got != 1) begin
                $display("FAIL bad_pin_%0d: got err %0d, expected 1", i, got); n_fail++;
            end
        end
        n_tests++;
        if (retain_cnt != r0 + 1) begin
            $display("FAIL lockout_retain: got %0d, expected 1", retain_cnt - r0); n_fail++;
        end
        cyc(1);
        pulse_card(1);
        got = next_err();
        n_tests++;
        if (got != 6 || state_out !== 4'd9 || retain_cnt != r0 + 2) begin
            $display("FAIL blocked_card: got err %0d state %0d retains %0d, expected 6 9 2",
                     got, state_out, retain_cnt - r0); n_fail++;
        end
        cyc(1);
        $display("[TB] txn acct=1 lockout retained");
    endtask

    task automatic test_withdraw_errors();
        // amount (-1 = day rollover) and the error each withdrawal must yield
        int amts[6] = '{30, 1020, 400, 120, -1, 120};
        int errs[6] = '{4, 2, 0, 3, 0, 0};
        int got;
        open_session(0);
        for (int i = 0; i < 6; i++) begin
            if (amts[i] < 0) begin
                pulse_roll();
                continue;
            end
            pulse_txn(2, amts[i]);
            if (errs[i] == 0) begin
                finish_dispense(2, 1'b0);
                model_debit(0, amts[i], 1'b0);
                got = next_disp();
                n_tests++;
                if (got != amts[i]) begin
                    $display("FAIL wd_step%0d_amt: got %0d, expected %0d", i, got, amts[i]); n_fail++;
                end
            end else begin
                got = next_err();
                n_tests++;
                if (got != errs[i]) begin
                    $display("FAIL wd_step%0d_err: got %0d, expected %0d", i, got, errs[i]); n_fail++;
                end
            end
            $display("[TB] txn acct=0 withdraw %0d err=%0d", amts[i], errs[i]);
        end
        pulse_txn(1, 0);
        got = next_bal();
        n_tests++;
        if (got != 480) begin
            $display("FAIL wd_errors_balance: got %0d, expected 480", got); n_fail++;
        end
        pulse_txn(0, 0);
    endtask

    task automatic test_deposit_sat();
        int got;
        open_session(3);
        pulse_txn(3, 65000);
        model_deposit(3, 65000);
        pulse_txn(1, 0);
        got = next_bal();
        n_tests++;
        if (got != 65535) begin
            $display("FAIL deposit_saturate: got %0d, expected 65535", got); n_fail++;
        end
        pulse_txn(0, 0);
        $display("[TB] txn acct=3 deposit 65000 balance=%0d", got);
    endtask

    task automatic test_pin_timeout();
        int code, waited, e0;
        e0 = eject_cnt;
        pulse_card(0);
        wait_err(TIMEOUT + 20, code, waited);
        n_tests++;
        if (code != 5) begin
            $display("FAIL pin_timeout_err: got %0d, expected 5", code); n_fail++;
        end
        n_tests++;
        if (waited < TIMEOUT - 4 || waited > TIMEOUT + 4) begin
            $display("FAIL pin_timeout_cycles: got %0d, expected about %0d", waited, TIMEOUT); n_fail++;
        end
        n_tests++;
        if (eject_cnt != e0 + 1) begin
            $display("FAIL pin_timeout_eject: got %0d, expected 1", eject_cnt - e0); n_fail++;
        end
        cyc(2);
        $display("[TB] txn acct=0 pin timeout after %0d cycles", waited);
    endtask

    task automatic test_dispense_timeout();
        int code, waited, got, e0;
        e0 = eject_cnt;
        open_session(0);
        pulse_txn(2, 20);
        void'(next_disp());
        wait_err(TIMEOUT + 20, code, waited);
        n_tests++;
        if (code != 7 || dispense_req !== 1'b0) begin
            $display("FAIL dispense_timeout: got err %0d req %0b, expected 7 0", code, dispense_req); n_fail++;
        end
        n_tests++;
        if (eject_cnt != e0 + 1) begin
            $display("FAIL dispense_timeout_eject: got %0d, expected 1", eject_cnt - e0); n_fail++;
        end
        cyc(2);
        open_session(0);
        pulse_txn(1, 0);
        got = next_bal();
        n_tests++;
        if (got != m_bal[0]) begin
            $display("FAIL dispense_timeout_nodebit: got %0d, expected %0d", got, m_bal[0]); n_fail++;
        end
        pulse_txn(0, 0);
        $display("[TB] txn acct=0 dispenser fault balance=%0d", got);
    endtask

    task automatic test_random();
        int a, t, amt, e, got, ntx;
        bit ok, retained, roll;
        for (int s = 0; s < 40; s++) begin
            a = $urandom_range(0, 3);
            if (m_blocked[a]) begin
                pulse_card(a);
                got = next_err();
                n_tests++;
                if (got != 6) begin
                    $display("FAIL rnd_blocked: acct %0d got err %0d, expected 6", a, got); n_fail++;
                end
                cyc(1);
                continue;
            end
            pulse_card(a);
            ok = 1'b0;
            retained = 1'b0;
            while (!ok && !retained) begin
                ok = ($urandom_range(0, 4) != 0);
                pulse_pin(ok);
                if (ok) begin
                    m_fail[a] = 0;
                end else begin
                    retained = model_wrong_pin(a);
                    got = next_err();
                    n_tests++;
                    if (got != 1) begin
                        $display("FAIL rnd_bad_pin: acct %0d got err %0d, expected 1", a, got); n_fail++;
                    end
                end
            end
            if (retained) begin
                cyc(1);
                $display("[TB] txn acct=%0d retained after bad PINs", a);
                continue;
            end
            ntx = $urandom_range(1, 4);
            for (int k = 0; k < ntx; k++) begin
                if ($urandom_range(0, 5) == 0) pulse_roll();
                t = $urandom_range(1, 3);
                if (t == 1) begin
                    pulse_txn(1, 0);
                    got = next_bal();
                    n_tests++;
                    if (got != m_bal[a]) begin
                        $display("FAIL rnd_balance: acct %0d got %0d, expected %0d", a, got, m_bal[a]); n_fail++;
                    end
                    $display("[TB] txn acct=%0d balance %0d", a, got);
                end else if (t == 2) begin
                    amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 700))
                                                      : 20 * int'($urandom_range(1, 30));
                    e = exp_wd(a, amt);
                    pulse_txn(2, amt);
                    if (e == 0) begin
                        roll = ($urandom_range(0, 3) == 0);
                        finish_dispense($urandom_range(0, 6), roll);
                        model_debit(a, amt, roll);
                        got = next_disp();
                        n_tests++;
                        if (got != amt) begin
                            $display("FAIL rnd_dispense: acct %0d got %0d, expected %0d", a, got, amt); n_fail++;
                        end
                    end else begin
                        got = next_err();
                        n_tests++;
                        if (got != e) begin
                            $display("FAIL rnd_wd_err: acct %0d amt %0d got %0d, expected %0d", a, amt, got, e); n_fail++;
                        end
                    end
                    $display("[TB] txn acct=%0d withdraw %0d err=%0d", a, amt, e);
                end else begin
                    amt = $urandom_range(0, 300);
                    pulse_txn(3, amt);
                    model_deposit(a, amt);
                    $display("[TB] txn acct=%0d deposit %0d", a, amt);
                end
            end
            pulse_txn(0, 0);
            n_tests++;
            if (err_q.size() != err_rd) begin
                $display("FAIL rnd_spurious_err: got %0d extra, expected 0", err_q.size() - err_rd); n_fail++;
                err_rd = err_q.size();
            end
        end
    endtask

    task automatic test_reset_mid_dispense();
        int got;
        do_reset();
        open_session(2);
        pulse_txn(2, 200);
        cyc(2);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (dispense_req !== 1'b0 || state_out !== 4'd0 || busy !== 1'b0 || dispense_amt !== 16'd0) begin
            $display("FAIL reset_mid_dispense: got req %0b state %0d busy %0b, expected 0 0 0",
                     dispense_req, state_out, busy); n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cyc(1);
        err_rd = err_q.size(); bal_rd = bal_q.size(); disp_rd = disp_q.size();
        open_session(2);
        pulse_txn(1, 0);
        got = next_bal();
        n_tests++;
        if (got != 1000) begin
            $display("FAIL reset_restores_balance: got %0d, expected 1000", got); n_fail++;
        end
        pulse_txn(0, 0);
        pulse_card(1);
        n_tests++;
        if (state_out !== 4'd1) begin
            $display("FAIL reset_clears_block: got state %0d, expected 1", state_out); n_fail++;
        end
        pulse_pin(1'b1);
        pulse_txn(0, 0);
        $display("[TB] txn reset during dispense, balance=%0d", got);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        card_in = 1'b0; acct_id = '0; pin_valid = 1'b0; pin_ok = 1'b0;
        txn_valid = 1'b0; txn_type = '0; amount = '0; day_rollover = 1'b0;
        dispense_done = 1'b0;
        model_reset();
        test_reset();
        test_withdraw_basic();
        test_lockout();
        test_withdraw_errors();
        test_deposit_sat();
        test_pin_timeout();
        test_dispense_timeout();
        test_random();
        test_reset_mid_dispense();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
